trap_ctrl: RTL and testbench

- Trap sequencer between the decode/execute/LSU exception flags and the CSR file.
- Each cycle it samples the per-instruction exception flags and the interrupt-accept flag, picks the highest-priority cause, and drives the pipeline flush handshake.
- It then redirects the PC to the trap vector or to mepc on mret, and issues one-cycle CSR update strobes.
- Strobes update mepc, mcause, mtval and mstatus.MIE/MPIE. Machine mode only.

---
 rtl/trap_pkg.sv | 26 ++
 rtl/trap_prio_enc.sv | 70 +++++++
 rtl/trap_ctrl.sv | 153 +++++++++++++++
 tb/tb_trap_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared trap sequencer definitions: cause codes, FSM states, mtvec mode.
package trap_pkg;

   localparam logic [4:0] CAUSE_INS_ADDR_MIS   = 5'd0;
   localparam logic [4:0] CAUSE_INS_ACC_FAULT  = 5'd1;
   localparam logic [4:0] CAUSE_ILL_INS        = 5'd2;
   localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
   localparam logic [4:0] CAUSE_LD_ADDR_MIS    = 5'd4;
   localparam logic [4:0] CAUSE_LD_ACC_FAULT   = 5'd5;
   localparam logic [4:0] CAUSE_ST_ADDR_MIS    = 5'd6;
   localparam logic [4:0] CAUSE_ST_ACC_FAULT   = 5'd7;
   localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;
   localparam logic [4:0] CAUSE_INS_PAGE_FAULT = 5'd12;
   localparam logic [4:0] CAUSE_LD_PAGE_FAULT  = 5'd13;
   localparam logic [4:0] CAUSE_ST_PAGE_FAULT  = 5'd15;

   // mtvec[1:0] encoding selecting vectored interrupt dispatch
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } trap_state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap cause selector: interrupt first, then fixed synchronous order, mret last.
module trap_prio_enc
   import trap_pkg::*;
(
   input  logic       i_valid,
   input  logic       i_ins_addr_mis,
   input  logic       i_ins_acc_fault,
   input  logic       i_ins_page_fault,
   input  logic       i_ill_ins,
   input  logic       i_ecall,
   input  logic       i_ebreak,
   input  logic       i_m_ret,
   input  logic       i_ld_addr_mis,
   input  logic       i_st_addr_mis,
   input  logic       i_ld_acc_fault,
   input  logic       i_st_acc_fault,
   input  logic       i_ld_page_fault,
   input  logic       i_st_page_fault,
   input  logic       i_int_acc,
   input  logic       i_mstatus_mie,
   input  logic [4:0] i_int_cause,
   output logic       o_hit,
   output logic       o_is_int,
   output logic       o_is_mret,
   output logic [4:0] o_code,
   output logic       o_use_tval
);

   // Pick the winning event; use_tval marks causes whose mtval is the faulting value
   always_comb begin
      o_hit      = 1'b0;
      o_is_int   = 1'b0;
      o_is_mret  = 1'b0;
      o_code     = 5'd0;
      o_use_tval = 1'b0;
      if (i_int_acc && i_mstatus_mie) begin
         o_hit    = 1'b1;
         o_is_int = 1'b1;
         o_code   = i_int_cause;
      end else if (i_valid) begin
         o_hit      = 1'b1;
         o_use_tval = 1'b1;
         if (i_ins_page_fault)     o_code = CAUSE_INS_PAGE_FAULT;
         else if (i_ins_acc_fault) o_code = CAUSE_INS_ACC_FAULT;
         else if (i_ill_ins)       o_code = CAUSE_ILL_INS;
         else if (i_ins_addr_mis)  o_code = CAUSE_INS_ADDR_MIS;
         else if (i_ecall) begin
            o_code     = CAUSE_ECALL_M;
            o_use_tval = 1'b0;
         end else if (i_ebreak) begin
            o_code     = CAUSE_BREAKPOINT;
            o_use_tval = 1'b0;
         end
         else if (i_st_addr_mis)   o_code = CAUSE_ST_ADDR_MIS;
         else if (i_ld_addr_mis)   o_code = CAUSE_LD_ADDR_MIS;
         else if (i_st_page_fault) o_code = CAUSE_ST_PAGE_FAULT;
         else if (i_ld_page_fault) o_code = CAUSE_LD_PAGE_FAULT;
         else if (i_st_acc_fault)  o_code = CAUSE_ST_ACC_FAULT;
         else if (i_ld_acc_fault)  o_code = CAUSE_LD_ACC_FAULT;
         else if (i_m_ret) begin
            o_is_mret  = 1'b1;
            o_use_tval = 1'b0;
         end else begin
            o_hit      = 1'b0;
            o_use_tval = 1'b0;
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: captures the winning event, flushes the pipe, then redirects the PC
// and fires a single CSR update strobe.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic [XLEN-1:0] ins_pc,
   input  logic [XLEN-1:0] ins_tval,
   input  logic            ins_addr_mis,
   input  logic            ins_acc_fault,
   input  logic            ins_page_fault,
   input  logic            ill_ins,
   input  logic            ecall,
   input  logic            ebreak,
   input  logic            m_ret,
   input  logic            ld_addr_mis,
   input  logic            st_addr_mis,
   input  logic            ld_acc_fault,
   input  logic            st_acc_fault,
   input  logic            ld_page_fault,
   input  logic            st_page_fault,
   input  logic            int_acc,
   input  logic [4:0]      int_cause,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic            mstatus_mie,
   output logic            flush_req,
   input  logic            flush_ack,
   output logic            pc_redirect,
   output logic [XLEN-1:0] pc_target,
   output logic            csr_trap_we,
   output logic            csr_mret_we,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mtval_o,
   output logic [XLEN-1:0] mcause_o,
   output logic            busy
);

   trap_state_t     r_state;
   trap_state_t     w_state_nxt;

   logic            w_hit;
   logic            w_is_int;
   logic            w_is_mret;
   logic [4:0]      w_code;
   logic            w_use_tval;
   logic            w_capture;
   logic [XLEN-1:0] w_mcause;
   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_target;

   logic            r_is_int;
   logic            r_is_mret;
   logic [4:0]      r_code;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mtval;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_pc_target;

   trap_prio_enc u_prio (
      .i_valid          (valid),
      .i_ins_addr_mis   (ins_addr_mis),
      .i_ins_acc_fault  (ins_acc_fault),
      .i_ins_page_fault (ins_page_fault),
      .i_ill_ins        (ill_ins),
      .i_ecall          (ecall),
      .i_ebreak         (ebreak),
      .i_m_ret          (m_ret),
      .i_ld_addr_mis    (ld_addr_mis),
      .i_st_addr_mis    (st_addr_mis),
      .i_ld_acc_fault   (ld_acc_fault),
      .i_st_acc_fault   (st_acc_fault),
      .i_ld_page_fault  (ld_page_fault),
      .i_st_page_fault  (st_page_fault),
      .i_int_acc        (int_acc),
      .i_mstatus_mie    (mstatus_mie),
      .i_int_cause      (int_cause),
      .o_hit            (w_hit),
      .o_is_int         (w_is_int),
      .o_is_mret        (w_is_mret),
      .o_code           (w_code),
      .o_use_tval       (w_use_tval)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; events seen outside IDLE are dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_hit) w_state_nxt = FLUSH;
         FLUSH:    if (flush_ack) w_state_nxt = REDIRECT;
         REDIRECT: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   assign w_capture = (r_state == IDLE) && w_hit;
   assign w_mcause  = {w_is_int, {(XLEN-6){1'b0}}, w_code};

   // Capture the trap payload on the recognising edge; mret leaves trap values untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_int  <= 1'b0;
         r_is_mret <= 1'b0;
         r_code    <= 5'd0;
         r_mepc    <= '0;
         r_mtval   <= '0;
         r_mcause  <= '0;
      end else if (w_capture) begin
         r_is_int  <= w_is_int;
         r_is_mret <= w_is_mret;
         r_code    <= w_code;
         if (!w_is_mret) begin
            r_mepc   <= ins_pc;
            r_mtval  <= w_use_tval ? ins_tval : '0;
            r_mcause <= w_mcause;
         end
      end
   end

   // Redirect target uses the live mtvec/mepc seen during REDIRECT
   assign w_base   = {mtvec[XLEN-1:2], 2'b00};
   assign w_target = r_is_mret ? mepc :
                     (r_is_int && (mtvec[1:0] == MTVEC_VECTORED)) ?
                        w_base + (XLEN'(r_code) << 2) : w_base;

   // Hold the last issued target between redirects
   always_ff @(posedge clk) begin
      if (rst)                      r_pc_target <= RESET_PC;
      else if (r_state == REDIRECT) r_pc_target <= w_target;
   end

   assign flush_req   = (r_state == FLUSH);
   assign busy        = (r_state != IDLE);
   assign pc_redirect = (r_state == REDIRECT);
   assign csr_trap_we = (r_state == REDIRECT) && !r_is_mret;
   assign csr_mret_we = (r_state == REDIRECT) &&  r_is_mret;
   assign pc_target   = (r_state == REDIRECT) ? w_target : r_pc_target;
   assign mepc_o      = r_mepc;
   assign mtval_o     = r_mtval;
   assign mcause_o    = r_mcause;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed literal checks plus randomized traffic against a
// behavioural model that is compared on every cycle.
module tb_trap_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] ins_pc, ins_tval, mtvec, mepc;
   logic        ins_addr_mis, ins_acc_fault, ins_page_fault;
   logic        ill_ins, ecall, ebreak, m_ret;
   logic        ld_addr_mis, st_addr_mis, ld_acc_fault, st_acc_fault;
   logic        ld_page_fault, st_page_fault;
   logic        int_acc, mstatus_mie, flush_ack;
   logic [4:0]  int_cause;
   logic        flush_req, pc_redirect, csr_trap_we, csr_mret_we, busy;
   logic [31:0] pc_target, mepc_o, mtval_o, mcause_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .valid(valid), .ins_pc(ins_pc), .ins_tval(ins_tval),
      .ins_addr_mis(ins_addr_mis), .ins_acc_fault(ins_acc_fault),
      .ins_page_fault(ins_page_fault), .ill_ins(ill_ins), .ecall(ecall),
      .ebreak(ebreak), .m_ret(m_ret), .ld_addr_mis(ld_addr_mis),
      .st_addr_mis(st_addr_mis), .ld_acc_fault(ld_acc_fault),
      .st_acc_fault(st_acc_fault), .ld_page_fault(ld_page_fault),
      .st_page_fault(st_page_fault), .int_acc(int_acc), .int_cause(int_cause),
      .mtvec(mtvec), .mepc(mepc), .mstatus_mie(mstatus_mie),
      .flush_req(flush_req), .flush_ack(flush_ack), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .csr_trap_we(csr_trap_we), .csr_mret_we(csr_mret_we),
      .mepc_o(mepc_o), .mtval_o(mtval_o), .mcause_o(mcause_o), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = idle, 1 = waiting for pipeline drain, 2 = redirect cycle
   int          m_phase  = 0;
   logic        m_int    = 1'b0;
   logic        m_mret   = 1'b0;
   logic [4:0]  m_code   = 5'd0;
   logic [31:0] m_mepc   = 32'h0;
   logic [31:0] m_mtval  = 32'h0;
   logic [31:0] m_mcause = 32'h0;
   logic [31:0] m_last   = RST_PC;

   function automatic logic [31:0] model_target();
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
      if (m_mret) return mepc;
      if (m_int && (mtvec[1:0] == 2'b01)) return base + 32'(m_code) * 32'd4;
      return base;
   endfunction

   task automatic model_step();
      logic [11:0] fl;
      int          codes [12];
      int          win;
      codes = '{12, 1, 2, 0, 11, 3, 6, 4, 15, 13, 7, 5};
      fl = {ld_acc_fault, st_acc_fault, ld_page_fault, st_page_fault, ld_addr_mis,
            st_addr_mis, ebreak, ecall, ins_addr_mis, ill_ins, ins_acc_fault, ins_page_fault};
      if (rst) begin
         m_phase = 0; m_int = 0; m_mret = 0; m_code = 0;
         m_mepc = 0; m_mtval = 0; m_mcause = 0; m_last = RST_PC;
      end else if (m_phase == 0) begin
         win = -1;
         if (valid) for (int i = 11; i >= 0; i--) if (fl[i]) win = i;
         if (int_acc && mstatus_mie) begin
            m_phase = 1; m_int = 1; m_mret = 0; m_code = int_cause;
            m_mepc = ins_pc; m_mtval = 0; m_mcause = 32'h8000_0000 | 32'(int_cause);
         end else if (win >= 0) begin
            m_phase = 1; m_int = 0; m_mret = 0; m_code = 5'(codes[win]);
            m_mepc = ins_pc; m_mcause = 32'(codes[win]);
            m_mtval = (win == 4 || win == 5) ? 32'h0 : ins_tval;
         end else if (valid && m_ret) begin
            m_phase = 1; m_int = 0; m_mret = 1;
         end
      end else if (m_phase == 1) begin
         if (flush_ack) m_phase = 2;
      end else begin
         m_last  = model_target();
         m_phase = 0;
      end
   endtask

   // Compare every cycle at the falling edge, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      logic red;
      red = (m_phase == 2);
      chk("busy",        32'(busy),        32'(m_phase != 0));
      chk("flush_req",   32'(flush_req),   32'(m_phase == 1));
      chk("pc_redirect", 32'(pc_redirect), 32'(red));
      chk("csr_trap_we", 32'(csr_trap_we), 32'(red && !m_mret));
      chk("csr_mret_we", 32'(csr_mret_we), 32'(red && m_mret));
      chk("pc_target",   pc_target,        red ? model_target() : m_last);
      chk("mepc_o",      mepc_o,           m_mepc);
      chk("mtval_o",     mtval_o,          m_mtval);
      chk("mcause_o",    mcause_o,         m_mcause);
      model_step();
   end

   // ---------------- stimulus ----------------
   task automatic clr();
      valid = 0; ins_addr_mis = 0; ins_acc_fault = 0; ins_page_fault = 0;
      ill_ins = 0; ecall = 0; ebreak = 0; m_ret = 0; ld_addr_mis = 0;
      st_addr_mis = 0; ld_acc_fault = 0; st_acc_fault = 0; ld_page_fault = 0;
      st_page_fault = 0; int_acc = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int sel;
      logic [31:0] r;
      rst = 1; clr(); ins_pc = 0; ins_tval = 0; mtvec = 0; mepc = 0;
      mstatus_mie = 0; flush_ack = 0; int_cause = 0;
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flush", 32'(flush_req), 0);
      chk("rst_pc", pc_target, RST_PC);
      chk("rst_mcause", mcause_o, 0);
      tick(); rst = 0;

      // illegal instruction, immediate drain
      valid = 1; ill_ins = 1; ins_pc = 32'h100; ins_tval = 32'hDEAD; mtvec = 32'h200; flush_ack = 1;
      tick(); clr();
      @(negedge clk);
      chk("ill_flush", 32'(flush_req), 1);
      tick();
      @(negedge clk);
      chk("ill_redir", 32'(pc_redirect), 1);
      chk("ill_target", pc_target, 32'h200);
      chk("ill_trap_we", 32'(csr_trap_we), 1);
      chk("ill_mcause", mcause_o, 32'd2);
      chk("ill_mepc", mepc_o, 32'h100);
      chk("ill_mtval", mtval_o, 32'hDEAD);
      tick();
      @(negedge clk);
      chk("ill_idle", 32'(busy), 0);

      // vectored interrupt
      mstatus_mie = 1; int_acc = 1; int_cause = 5'd7; mtvec = 32'h301;
      tick(); clr();
      tick();
      @(negedge clk);
      chk("int_mcause", mcause_o, 32'h8000_0007);
      chk("int_target", pc_target, 32'h31C);
      chk("int_mtval", mtval_o, 32'h0);
      tick();

      // priority pairs
      valid = 1; ld_addr_mis = 1; ins_page_fault = 1;
      tick(); clr();
      @(negedge clk);
      chk("prio_ipf", mcause_o, 32'd12);
      tick(); tick();
      valid = 1; ecall = 1; st_acc_fault = 1;
      tick(); clr();
      @(negedge clk);
      chk("prio_ecall", mcause_o, 32'd11);
      chk("ecall_mtval", mtval_o, 32'h0);
      tick(); tick();

      // mret with a 5-cycle drain
      flush_ack = 0; mepc = 32'h4444; valid = 1; m_ret = 1;
      tick(); clr();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) flush_ack = 1;
         @(negedge clk);
         chk("mret_hold", 32'(flush_req), 1);
         tick();
      end
      flush_ack = 0;
      @(negedge clk);
      chk("mret_redir", 32'(pc_redirect), 1);
      chk("mret_target", pc_target, 32'h4444);
      chk("mret_we", 32'(csr_mret_we), 1);
      chk("mret_no_trap", 32'(csr_trap_we), 0);
      tick();

      // second ecall while flushing is ignored
      valid = 1; ecall = 1; ins_pc = 32'h500;
      tick(); ins_pc = 32'h504;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin clr(); flush_ack = 1; end
         @(negedge clk);
         pulses += 32'(csr_trap_we);
         tick();
      end
      flush_ack = 0;
      chk("one_pulse", 32'(pulses), 1);
      chk("first_mepc", mepc_o, 32'h500);

      // reset in the middle of a flush
      valid = 1; ecall = 1;
      tick(); clr();
      @(negedge clk);
      chk("pre_rst_flush", 32'(flush_req), 1);
      tick(); rst = 1; flush_ack = 1;
      tick(); rst = 0; flush_ack = 0;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_pc", pc_target, RST_PC);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pulses += 32'(csr_trap_we) + 32'(csr_mret_we) + 32'(pc_redirect);
         tick();
      end
      chk("rst_no_strobe", 32'(pulses), 0);

      // randomized traffic, checked by the model
      for (int n = 0; n < 3000; n++) begin
         tick();
         clr();
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom();
            valid = r[0];
            sel = $urandom_range(0, 3);
            ins_addr_mis   = r[1]  & (sel == 0); ins_acc_fault  = r[2]  & (sel != 1);
            ins_page_fault = r[3]  & (sel == 2); ill_ins        = r[4]  & (sel != 3);
            ecall          = r[5]  & (sel == 1); ebreak         = r[6]  & (sel != 0);
            m_ret          = r[7];
            ld_addr_mis    = r[8]  & (sel == 3); st_addr_mis    = r[9]  & (sel != 2);
            ld_acc_fault   = r[10] & (sel == 0); st_acc_fault   = r[11] & (sel == 1);
            ld_page_fault  = r[12] & (sel == 2); st_page_fault  = r[13] & (sel == 3);
            if (r[14] && r[15]) begin
               ins_addr_mis = 0; ins_acc_fault = 0; ins_page_fault = 0; ill_ins = 0;
               ecall = 0; ebreak = 0; ld_addr_mis = 0; st_addr_mis = 0;
               ld_acc_fault = 0; st_acc_fault = 0; ld_page_fault = 0; st_page_fault = 0;
               valid = 1; m_ret = 1;
            end
         end
         int_acc     = ($urandom_range(0, 9) == 0);
         mstatus_mie = ($urandom_range(0, 3) != 0);
         int_cause   = 5'($urandom_range(0, 31));
         ins_pc      = $urandom();
         ins_tval    = $urandom();
         mtvec       = $urandom();
         mepc        = $urandom();
         flush_ack   = ($urandom_range(0, 2) == 0);
      end
      tick();
      rst = 1;
      tick();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
